// File: rtl/systolic_loop_counter.sv
// Three-level (column, row, tile) index generator for the systolic array.
// Bounds, repeat mode and the run itself are captured on start. Indices step
// on advance, column fastest. A run ends with a one-cycle done, or it wraps
// forever in continuous mode until abort.
//
// Control handshake: start is a single-cycle request that is only honoured in
// IDLE. advance is a per-cycle enable while valid is high: a cycle with
// valid=1 and advance=1 consumes the current tuple, and a cycle with
// advance=0 holds it. abort is synchronous and overrides everything else.
module systolic_loop_counter #(
  parameter int MAX_COLS  = 32,
  parameter int MAX_ROWS  = 32,
  parameter int MAX_TILES = 16,
  localparam int CW = (MAX_COLS  > 1) ? $clog2(MAX_COLS)  : 1,
  localparam int RW = (MAX_ROWS  > 1) ? $clog2(MAX_ROWS)  : 1,
  localparam int TW = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          continuous,
  input  logic [CW-1:0] cfg_col_last,
  input  logic [RW-1:0] cfg_row_last,
  input  logic [TW-1:0] cfg_tile_last,
  input  logic          advance,
  output logic [CW-1:0] col_cntr,
  output logic [RW-1:0] row_cntr,
  output logic [TW-1:0] tile_cntr,
  output logic          valid,
  output logic          col_last,
  output logic          row_last,
  output logic          tile_last,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Largest legal "last index" per level. The comparison is done one bit
  // wider so it stays a real compare when the maximum is a power of two.
  localparam logic [CW:0] COL_LIMIT  = (CW+1)'(MAX_COLS  - 1);
  localparam logic [RW:0] ROW_LIMIT  = (RW+1)'(MAX_ROWS  - 1);
  localparam logic [TW:0] TILE_LIMIT = (TW+1)'(MAX_TILES - 1);

  state_t        state, next_state;
  logic [CW-1:0] col_bound;
  logic [RW-1:0] row_bound;
  logic [TW-1:0] tile_bound;
  logic          cont_q;

  logic at_col, at_row, at_tile, final_pt;
  logic cfg_bad, accept, reject;

  assign at_col   = (col_cntr  == col_bound);
  assign at_row   = (row_cntr  == row_bound);
  assign at_tile  = (tile_cntr == tile_bound);
  assign final_pt = at_col && at_row && at_tile;

  assign cfg_bad = ({1'b0, cfg_col_last}  > COL_LIMIT) ||
                   ({1'b0, cfg_row_last}  > ROW_LIMIT) ||
                   ({1'b0, cfg_tile_last} > TILE_LIMIT);

  // abort in IDLE suppresses both acceptance and rejection of start.
  assign accept = (state == S_IDLE) && start && !abort && !cfg_bad;
  assign reject = (state == S_IDLE) && start && !abort &&  cfg_bad;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; abort takes precedence over stepping and completion.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept) next_state = S_RUN;
      S_RUN: begin
        if (abort)                                next_state = S_IDLE;
        else if (advance && final_pt && !cont_q)  next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Bound capture and the nested index counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_bound  <= '0;
      row_bound  <= '0;
      tile_bound <= '0;
      cont_q     <= 1'b0;
      col_cntr   <= '0;
      row_cntr   <= '0;
      tile_cntr  <= '0;
    end else if (accept) begin
      col_bound  <= cfg_col_last;
      row_bound  <= cfg_row_last;
      tile_bound <= cfg_tile_last;
      cont_q     <= continuous;
      col_cntr   <= '0;
      row_cntr   <= '0;
      tile_cntr  <= '0;
    end else if (abort && (state == S_RUN || state == S_DONE)) begin
      col_cntr  <= '0;
      row_cntr  <= '0;
      tile_cntr <= '0;
    end else if (state == S_RUN && advance && !(final_pt && !cont_q)) begin
      // At the final point in continuous mode every level wraps to zero.
      if (at_col) begin
        col_cntr <= '0;
        if (at_row) begin
          row_cntr <= '0;
          if (at_tile) tile_cntr <= '0;
          else         tile_cntr <= tile_cntr + TW'(1);
        end else begin
          row_cntr <= row_cntr + RW'(1);
        end
      end else begin
        col_cntr <= col_cntr + CW'(1);
      end
    end
  end

  // Rejected-configuration pulse, one cycle after the offending start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= reject;
  end

  assign valid     = (state == S_RUN);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign col_last  = valid && at_col;
  assign row_last  = valid && at_row;
  assign tile_last = valid && at_tile;

endmodule

// File: doc/systolic_loop_counter.md
Name: systolic_loop_counter

Overview:
Three-level nested index generator (column, row, tile) that drives operand feeding and result drain for the systolic matrix-multiply array. It generalises the fixed WIDTH x HEIGHT pixel/slice counter in three ways: runtime-programmable bounds up to parametrised maxima, a third tile dimension, and a start/done handshake with stall, abort and continuous-repeat mode. It sits between the top-level controller and the array-feed/address logic.

Parameters:
MAX_COLS, 32, maximum column count; CW = max(clog2(MAX_COLS),1)
MAX_ROWS, 32, maximum row count; RW = max(clog2(MAX_ROWS),1)
MAX_TILES, 16, maximum tile count; TW = max(clog2(MAX_TILES),1)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start  in  1  pulse; begins a run when in IDLE
abort  in  1  synchronous; terminates a run without done
continuous  in  1  sampled at start; 1 = wrap to origin and repeat instead of finishing
cfg_col_last  in  CW  last column index (count-1); sampled at start
cfg_row_last  in  RW  last row index; sampled at start
cfg_tile_last  in  TW  last tile index; sampled at start
advance  in  1  step enable; 0 = stall, indices hold
col_cntr  out  CW  current column index
row_cntr  out  RW  current row index
tile_cntr  out  TW  current tile index
valid  out  1  indices are meaningful (state RUN)
col_last  out  1  valid and col_cntr == latched col bound
row_last  out  1  valid and row_cntr == latched row bound
tile_last  out  1  valid and tile_cntr == latched tile bound
busy  out  1  state RUN
done  out  1  one-cycle pulse at normal completion
cfg_err  out  1  one-cycle pulse: start rejected

Behaviour:
- Reset (async, any state): state IDLE; all counters and latched bounds 0; valid, busy, done, cfg_err, and the latched continuous flag 0.
- States: IDLE, RUN, DONE. Encoding is free; unreachable encodings recover to IDLE.
- IDLE, start=1:
  - If any cfg field exceeds its maximum-1 (reachable only when MAX is not a power of 2): cfg_err=1 next cycle, stay IDLE, latched bounds unchanged.
  - Otherwise: latch bounds and continuous, counters to 0, go to RUN. valid=1 in the cycle after start (latency 1).
- RUN, advance=0: all counters hold; flags hold.
- RUN, advance=1, stepping:
  - col increments.
  - At col == col bound: col goes to 0 and row increments.
  - At row == row bound as well: row goes to 0 and tile increments.
  - At the final point (col, row and tile all at their bounds):
    - Latched continuous=1: all counters go to 0, stay RUN, no done.
    - Otherwise: go to DONE.
- Counters never exceed their latched bounds. A bound of 0 means that level is always at its last index.
- DONE: done=1 and valid=0 for exactly one cycle, then IDLE. Counters hold their final values until the next start.
- start while RUN or DONE: ignored.
- abort=1 in RUN or DONE: next state IDLE, counters 0, no done pulse.
  - abort has priority over advance and over completion.
  - abort with start in IDLE: abort wins; start is ignored.
- continuous may be cleared mid-run only via abort; the latched value is not re-sampled.
- Throughput: one index tuple per cycle with advance held high. A run with C,R,T counts takes C*R*T valid cycles with advance=1, then the done cycle.

Test Plan:
1. Reset, start with cfg 2/1/0, advance=1 from start -> cycles 1..6 valid with (col,row) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1), tile 0. col_last in cycles 3 and 6; row_last in cycles 4-6. done=1 at cycle 7; busy=0 and valid=0 at cycle 8.
2. Same config, advance toggled 1,0,1,0... -> identical index sequence, each tuple held 2 cycles. done follows the 12th valid cycle.
3. cfg 1/1/1, continuous=1 -> sequence of 8 tuples, then (0,0,0) again with no done. abort at tuple 11 -> IDLE next cycle, all counters 0, done never asserted.
4. MAX_COLS=24, cfg_col_last=24 -> cfg_err pulse, valid stays 0. Retry with 23 -> runs 24 columns per row.
5. Assert async rst mid-run between clock edges -> outputs zero immediately, before the next edge. Release, start -> clean run from (0,0,0).
6. cfg all 0 -> single valid cycle with all last flags=1, then done. start asserted during RUN -> ignored; sequence unaffected.
